lock_core_param: RTL

//  Parametrised successor to the two-bit switch lock: stores a PW_LEN-digit code of DIGIT_W-bit digits.

---
 rtl/lock_core_param.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/lock_core_param.sv
// lock_core_param: parameterised digit-code lock.
// Stores a PW_LEN-digit code of DIGIT_W-bit digits, checks entered codes on
// submit, and locks out for LOCKOUT_CYCLES after MAX_FAILS consecutive misses.
// Optional feature macro: LOCK_AUTO_RELOCK_EN (idle auto-relock from UNLOCKED
// after RELOCK_CYCLES cycles without a button edge).
module lock_core_param #(
    parameter int DIGIT_W        = 2,
    parameter int PW_LEN         = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int RELOCK_CYCLES  = 256
) (
    input  logic                             clk,
    input  logic                             system_reset_n,
    input  logic                             store_button,
    input  logic                             input_button,
    input  logic                             submit_button,
    input  logic [DIGIT_W-1:0]               digits,
    output logic                             unlock,
    output logic                             sleep,
    output logic                             correct_password,
    output logic                             invalid_password,
    output logic                             store_error,
    output logic [$clog2(PW_LEN+1)-1:0]      entry_count,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count
);

    localparam int BW  = PW_LEN * DIGIT_W;
    localparam int ECW = $clog2(PW_LEN + 1);
    localparam int FCW = $clog2(MAX_FAILS + 1);
    localparam int LW  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [ECW-1:0] EC_FULL = ECW'(PW_LEN);
    localparam logic [FCW-1:0] FC_LAST = FCW'(MAX_FAILS - 1);
    localparam logic [LW-1:0]  LO_LOAD = LW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_SETUP    = 2'd0,
        S_LOCKED   = 2'd1,
        S_UNLOCKED = 2'd2,
        S_LOCKOUT  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            store_q, input_q, submit_q;
    logic [BW-1:0]   buf_q, buf_d;
    logic [BW-1:0]   code_q, code_d;
    logic            ovf_q, ovf_d;
    logic [ECW-1:0]  ec_q, ec_d;
    logic [FCW-1:0]  fc_q, fc_d;
    logic [LW-1:0]   lo_q, lo_d;
    logic            cp_q, cp_d, ip_q, ip_d, se_q, se_d;

    logic st_e, in_e, sub_e, any_e;
    logic do_sub, do_st, do_in;
    logic store_ok, match, fail_last, lo_done, relock_fire;

    // Rising-edge detect; submit outranks store, store outranks input.
    assign st_e   = store_button  & ~store_q;
    assign in_e   = input_button  & ~input_q;
    assign sub_e  = submit_button & ~submit_q;
    assign any_e  = st_e | in_e | sub_e;
    assign do_sub = sub_e;
    assign do_st  = st_e & ~sub_e;
    assign do_in  = in_e & ~st_e & ~sub_e;

    assign store_ok  = (ec_q == EC_FULL) && !ovf_q;
    assign match     = store_ok && (buf_q == code_q);
    assign fail_last = (fc_q == FC_LAST);
    assign lo_done   = (lo_q == '0);

`ifdef LOCK_AUTO_RELOCK_EN
    localparam int RW = (RELOCK_CYCLES > 1) ? $clog2(RELOCK_CYCLES) : 1;
    localparam logic [RW-1:0] IDLE_LAST = RW'(RELOCK_CYCLES - 1);

    logic [RW-1:0] idle_q;

    // Idle counter: runs only in UNLOCKED, any button edge restarts it.
    always_ff @(posedge clk or negedge system_reset_n) begin
        if (!system_reset_n)                          idle_q <= '0;
        else if (state_q != S_UNLOCKED || any_e)      idle_q <= '0;
        else if (idle_q != IDLE_LAST)                 idle_q <= idle_q + 1'b1;
    end

    assign relock_fire = (state_q == S_UNLOCKED) && !any_e && (idle_q == IDLE_LAST);
`else
    logic unused_relock;
    assign unused_relock = any_e ^ (RELOCK_CYCLES != 0);
    assign relock_fire   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge system_reset_n) begin
        if (!system_reset_n) state_q <= S_SETUP;
        else                 state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_SETUP:    if (do_st && store_ok) state_d = S_LOCKED;
            S_LOCKED:   if (do_sub) begin
                            if (match)          state_d = S_UNLOCKED;
                            else if (fail_last) state_d = S_LOCKOUT;
                        end
            S_UNLOCKED: if (do_sub || (do_st && store_ok) || relock_fire) state_d = S_LOCKED;
            S_LOCKOUT:  if (lo_done) state_d = S_LOCKED;
            default:    state_d = S_SETUP;
        endcase
    end

    // Outputs: levels decoded from state, pulses from registers.
    always_comb begin
        unlock           = (state_q == S_UNLOCKED);
        sleep            = (state_q == S_LOCKOUT);
        correct_password = cp_q;
        invalid_password = ip_q;
        store_error      = se_q;
        entry_count      = ec_q;
        fail_count       = fc_q;
    end

    // Datapath next values: entry buffer, stored code, counters, pulses.
    always_comb begin
        logic clr;
        clr    = 1'b0;
        buf_d  = buf_q;
        ovf_d  = ovf_q;
        ec_d   = ec_q;
        code_d = code_q;
        fc_d   = fc_q;
        lo_d   = lo_q;
        cp_d   = 1'b0;
        ip_d   = 1'b0;
        se_d   = 1'b0;

        // Digit entry; full buffer flags overflow instead of shifting.
        if (do_in && state_q != S_LOCKOUT) begin
            if (ec_q < EC_FULL) begin
                buf_d = (buf_q << DIGIT_W) | BW'(digits);
                ec_d  = ec_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            S_SETUP, S_UNLOCKED: begin
                if (do_st) begin
                    clr = 1'b1;
                    if (store_ok) code_d = buf_q;
                    else          se_d   = 1'b1;
                end
                if (state_q == S_UNLOCKED && (do_sub || relock_fire)) clr = 1'b1;
            end
            S_LOCKED: begin
                if (do_sub) begin
                    clr = 1'b1;
                    if (match) begin
                        cp_d = 1'b1;
                        fc_d = '0;
                    end else begin
                        ip_d = 1'b1;
                        fc_d = fc_q + 1'b1;
                        if (fail_last) lo_d = LO_LOAD;
                    end
                end
            end
            S_LOCKOUT: begin
                clr = 1'b1;
                if (lo_done) fc_d = '0;
                else         lo_d = lo_q - 1'b1;
            end
            default: clr = 1'b1;
        endcase

        if (clr) begin
            buf_d = '0;
            ovf_d = 1'b0;
            ec_d  = '0;
        end
    end

    // Datapath and button-history registers.
    always_ff @(posedge clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            store_q  <= 1'b0;
            input_q  <= 1'b0;
            submit_q <= 1'b0;
            buf_q    <= '0;
            code_q   <= '0;
            ovf_q    <= 1'b0;
            ec_q     <= '0;
            fc_q     <= '0;
            lo_q     <= '0;
            cp_q     <= 1'b0;
            ip_q     <= 1'b0;
            se_q     <= 1'b0;
        end else begin
            store_q  <= store_button;
            input_q  <= input_button;
            submit_q <= submit_button;
            buf_q    <= buf_d;
            code_q   <= code_d;
            ovf_q    <= ovf_d;
            ec_q     <= ec_d;
            fc_q     <= fc_d;
            lo_q     <= lo_d;
            cp_q     <= cp_d;
            ip_q     <= ip_d;
            se_q     <= se_d;
        end
    end

endmodule
